prog_loader: RTL and testbench

Byte-stream program loader that sits directly upstream of the CPU's code bus. It receives a framed program image over a byte interface (typically a UART receiver), assembles 16-bit words, and writes them into program memory. It holds the CPU in reset until a complete image has passed its checksum, then releases it. A new frame arriving at any time re-asserts CPU reset and reloads.

---
 rtl/prog_loader_pkg.sv | 30 +++
 rtl/prog_loader_timer.sv | 42 ++++
 rtl/prog_loader.sv | 194 +++++++++++++++++++
 tb/tb_prog_loader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared definitions for the byte-stream program loader.
//   - prog_loader_state_t : loader FSM states
//   - LOADER_MAGIC        : frame start byte
//   - DEFAULT_*           : default parameter values
//   - in_frame()          : true for the states that make up an active frame
`ifndef CODE_ADDR_WIDTH
`define CODE_ADDR_WIDTH 13
`endif

package prog_loader_pkg;

  localparam int unsigned DEFAULT_CODE_ADDR_WIDTH = `CODE_ADDR_WIDTH;
  localparam int unsigned DEFAULT_TIMEOUT         = 1_000_000;
  localparam logic [7:0]  LOADER_MAGIC            = 8'hB5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_CSUM,
    ST_RUN
  } prog_loader_state_t;

  function automatic logic in_frame(input prog_loader_state_t s);
    return s inside {ST_LEN_LO, ST_LEN_HI, ST_DATA_LO, ST_DATA_HI, ST_CSUM};
  endfunction

endpackage

// File: rtl/prog_loader_timer.sv
// loader_timer: inter-byte idle timer for prog_loader.
//   clk       in  system clock
//   rst       in  asynchronous active-high reset
//   restart_i in  reload the counter (a byte was accepted this cycle)
//   expired_o out TIMEOUT cycles have elapsed since the last restart
//                 (asserted on the TIMEOUT-th edge without a restart)
module loader_timer
  import prog_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  localparam int unsigned W      = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Loaded with TIMEOUT-1 so that reaching zero and then seeing one more
  // edge without a byte accounts for exactly TIMEOUT idle edges.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = W'(TIMEOUT - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= W'(TIMEOUT - 1);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0) && !restart_i;

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a framed program image over a byte stream, writes
// 16-bit words into program memory and holds the CPU in reset until the
// image checksum has been verified.
//   Frame: B5, LEN_LO, LEN_HI, 2*N payload bytes (word low byte first), CSUM
//   where CSUM = XOR of every byte after the magic byte.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   rx_valid/rx_data      incoming byte stream
//   rx_ready              high from the first clock after reset onwards
//   code_we/waddr/wdata   program memory write port (one-cycle strobe)
//   cpu_reset             CPU held in reset while high
//   busy                  frame in progress
//   done                  verified image loaded, CPU running
//   error                 one-cycle pulse on frame abort
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned CODE_ADDR_WIDTH = DEFAULT_CODE_ADDR_WIDTH,
  parameter int unsigned TIMEOUT         = DEFAULT_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       rx_ready,
  output logic                       code_we,
  output logic [CODE_ADDR_WIDTH-1:0] code_waddr,
  output logic [15:0]                code_wdata,
  output logic                       cpu_reset,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam logic [32:0] MAX_WORDS = 33'(1) << CODE_ADDR_WIDTH;

  prog_loader_state_t state_q, state_d;

  logic                       rx_ready_q;
  logic [7:0]                 csum_q, csum_d;
  logic [7:0]                 len_lo_q, len_lo_d;
  logic [15:0]                len_q, len_d;
  logic [7:0]                 lo_q, lo_d;
  logic [CODE_ADDR_WIDTH:0]   widx_q, widx_d;
  logic                       we_q, we_d;
  logic [CODE_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [15:0]                wdata_q, wdata_d;
  logic                       cpu_reset_q, cpu_reset_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;

  logic                     accept;
  logic                     timer_expired;
  logic [7:0]               csum_nx;
  logic [15:0]              len_word;
  logic                     len_bad;
  logic [CODE_ADDR_WIDTH:0] widx_inc;
  logic                     last_word;

  assign accept    = rx_valid && rx_ready_q;
  assign csum_nx   = csum_q ^ rx_data;
  assign len_word  = {rx_data, len_lo_q};
  assign len_bad   = (len_word == '0) || (33'(len_word) > MAX_WORDS);
  assign widx_inc  = widx_q + (CODE_ADDR_WIDTH + 1)'(1);
  assign last_word = (33'(widx_inc) == 33'(len_q));

  loader_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (reset),
    .restart_i(accept),
    .expired_o(timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    csum_d      = csum_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    lo_d        = lo_q;
    widx_d      = widx_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = 1'b0;

    if (accept) begin
      unique case (state_q)
        ST_IDLE, ST_RUN: begin
          if (rx_data == LOADER_MAGIC) begin
            state_d     = ST_LEN_LO;
            cpu_reset_d = 1'b1;
            done_d      = 1'b0;
            csum_d      = '0;
            widx_d      = '0;
          end
        end
        ST_LEN_LO: begin
          len_lo_d = rx_data;
          csum_d   = csum_nx;
          state_d  = ST_LEN_HI;
        end
        ST_LEN_HI: begin
          len_d  = len_word;
          csum_d = csum_nx;
          if (len_bad) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          lo_d    = rx_data;
          csum_d  = csum_nx;
          state_d = ST_DATA_HI;
        end
        ST_DATA_HI: begin
          we_d    = 1'b1;
          waddr_d = widx_q[CODE_ADDR_WIDTH-1:0];
          wdata_d = {rx_data, lo_q};
          widx_d  = widx_inc;
          csum_d  = csum_nx;
          state_d = last_word ? ST_CSUM : ST_DATA_LO;
        end
        ST_CSUM: begin
          if (rx_data == csum_q) begin
            state_d     = ST_RUN;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timer_expired && in_frame(state_q)) begin
      error_d = 1'b1;
      state_d = ST_IDLE;
    end

    // busy is registered from the next state so it tracks state_q exactly.
    busy_d = in_frame(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rx_ready_q  <= 1'b0;
      csum_q      <= '0;
      len_lo_q    <= '0;
      len_q       <= '0;
      lo_q        <= '0;
      widx_q      <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= 1'b1;
      csum_q      <= csum_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      lo_q        <= lo_d;
      widx_q      <= widx_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign code_we    = we_q;
  assign code_waddr = waddr_q;
  assign code_wdata = wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed plus randomized frames for prog_loader with a
// small address space and short timeout. Expected writes, error pulses and
// final status are derived from how each frame was constructed.
module tb_prog_loader;

  localparam int unsigned AW    = 3;
  localparam int unsigned TMO   = 20;
  localparam int unsigned MAXW  = 1 << AW;
  localparam logic [7:0]  MAGIC = 8'hB5;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          code_we;
  logic [AW-1:0] code_waddr;
  logic [15:0]   code_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  prog_loader #(
    .CODE_ADDR_WIDTH(AW),
    .TIMEOUT        (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .code_we   (code_we),
    .code_waddr(code_waddr),
    .code_wdata(code_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Observed writes {addr, data} and error pulses, sampled on the falling edge.
  logic [31:0] wr_q[$];
  int unsigned err_seen = 0;

  always @(negedge clk) begin
    if (code_we === 1'b1) wr_q.push_back({16'(code_waddr), code_wdata});
    if (error === 1'b1) err_seen++;
  end

  // Reference frame: bytes to send and the words it should write.
  logic [7:0]  frame[$];
  logic [15:0] exp_words[$];

  task automatic make_frame(input int unsigned n, input logic [15:0] len);
    logic [7:0] cs;
    logic [15:0] w;
    frame.delete();
    exp_words.delete();
    frame.push_back(MAGIC);
    frame.push_back(len[7:0]);
    frame.push_back(len[15:8]);
    for (int unsigned i = 0; i < n; i++) begin
      w = 16'($urandom);
      exp_words.push_back(w);
      frame.push_back(w[7:0]);
      frame.push_back(w[15:8]);
    end
    cs = '0;
    for (int unsigned i = 1; i < frame.size(); i++) cs = cs ^ frame[i];
    frame.push_back(cs);
  endtask

  task automatic idle(input int unsigned n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns #1 after the edge that transfers the byte.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    idle(gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  function automatic int unsigned rand_gap();
    return ($urandom_range(0, 9) == 0) ? TMO - 1 : $urandom_range(0, 2);
  endfunction

  task automatic start_scenario();
    wr_q.delete();
    err_seen = 0;
  endtask

  task automatic finish_check(input string tag, input int unsigned nwr,
                              input int unsigned nerr, input logic exp_done);
    idle(3);
    check($sformatf("%s nwrites", tag), wr_q.size(), nwr);
    for (int unsigned i = 0; i < nwr && i < wr_q.size(); i++)
      check($sformatf("%s wr%0d", tag, i), wr_q[i], {16'(i), exp_words[i]});
    check($sformatf("%s errors", tag), err_seen, nerr);
    check($sformatf("%s done", tag), done, exp_done);
    check($sformatf("%s cpu_reset", tag), cpu_reset, !exp_done);
    check($sformatf("%s busy", tag), busy, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " rx_ready"}, rx_ready, 1'b0);
    check({tag, " code_we"}, code_we, 1'b0);
    check({tag, " code_waddr"}, code_waddr, '0);
    check({tag, " code_wdata"}, code_wdata, '0);
    check({tag, " cpu_reset"}, cpu_reset, 1'b1);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " done"}, done, 1'b0);
    check({tag, " error"}, error, 1'b0);
  endtask

  task automatic send_frame_all();
    for (int unsigned i = 0; i < frame.size(); i++) send_byte(frame[i], rand_gap());
  endtask

  task automatic run_random(input int unsigned kind, input int unsigned idx);
    int unsigned n, k, nexp;
    logic [15:0] len;
    logic [7:0]  g;
    string tag;
    tag = $sformatf("rnd%0d/k%0d", idx, kind);
    start_scenario();
    repeat ($urandom_range(0, 2)) begin
      g = 8'($urandom);
      if (g == MAGIC) g = 8'h00;
      send_byte(g, $urandom_range(0, 2));
    end
    case (kind)
      0, 1: begin
        n = $urandom_range(1, MAXW);
        make_frame(n, 16'(n));
        if (kind == 1) frame[frame.size() - 1] ^= 8'($urandom_range(1, 255));
        send_frame_all();
        finish_check(tag, n, kind, kind == 0);
      end
      2: begin
        case ($urandom_range(0, 2))
          0:       len = 16'd0;
          1:       len = 16'(MAXW + 1);
          default: len = 16'($urandom_range(MAXW + 1, 65535));
        endcase
        make_frame(0, len);
        for (int unsigned i = 0; i < 3; i++) send_byte(frame[i], rand_gap());
        finish_check(tag, 0, 1, 1'b0);
      end
      default: begin
        n = $urandom_range(1, MAXW);
        make_frame(n, 16'(n));
        k = $urandom_range(1, 2 * n + 2);
        for (int unsigned i = 0; i <= k; i++) send_byte(frame[i], rand_gap());
        idle(TMO + 2);
        nexp = (k >= 2) ? (k - 2) / 2 : 0;
        finish_check(tag, nexp, 1, 1'b0);
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;
    #1;
    check("rx_ready before first clock", rx_ready, 1'b0);
    @(posedge clk);
    #1;
    check("rx_ready after first clock", rx_ready, 1'b1);

    // Known-good single-word frame with cycle-exact output checks.
    start_scenario();
    exp_words.delete();
    exp_words.push_back(16'h1234);
    send_byte(MAGIC, 0);
    check("magic busy", busy, 1'b1);
    check("magic cpu_reset", cpu_reset, 1'b1);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h34, 0);
    check("lo no write", code_we, 1'b0);
    send_byte(8'h12, 0);
    check("hi code_we", code_we, 1'b1);
    check("hi code_waddr", code_waddr, 0);
    check("hi code_wdata", code_wdata, 16'h1234);
    send_byte(8'h27, 0);
    check("csum done", done, 1'b1);
    check("csum cpu_reset", cpu_reset, 1'b0);
    check("csum busy", busy, 1'b0);
    finish_check("good1", 1, 0, 1'b1);

    // Reload from RUN, back-to-back 3-word frame.
    start_scenario();
    make_frame(3, 16'd3);
    send_byte(frame[0], 0);
    check("reload cpu_reset", cpu_reset, 1'b1);
    check("reload done", done, 1'b0);
    for (int unsigned i = 1; i < frame.size(); i++) send_byte(frame[i], 0);
    check("good3 done next cycle", done, 1'b1);
    finish_check("good3", 3, 0, 1'b1);

    // Longest legal idle gap inside a frame does not abort it.
    start_scenario();
    make_frame(2, 16'd2);
    for (int unsigned i = 0; i < frame.size(); i++) send_byte(frame[i], (i == 3) ? TMO - 1 : 0);
    finish_check("gap max", 2, 0, 1'b1);

    // Bad checksum.
    start_scenario();
    exp_words.delete();
    exp_words.push_back(16'h1234);
    send_byte(MAGIC, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    send_byte(8'h00, 0);
    check("badcs error pulse", error, 1'b1);
    finish_check("badcs", 1, 1, 1'b0);

    // Zero length.
    start_scenario();
    send_byte(MAGIC, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("len0 error pulse", error, 1'b1);
    idle(1);
    check("len0 error cleared", error, 1'b0);
    finish_check("len0", 0, 1, 1'b0);

    // One word too many, then exactly full memory.
    start_scenario();
    make_frame(0, 16'(MAXW + 1));
    for (int unsigned i = 0; i < 3; i++) send_byte(frame[i], 0);
    finish_check("len max+1", 0, 1, 1'b0);
    start_scenario();
    make_frame(MAXW, 16'(MAXW));
    send_frame_all();
    finish_check("len max", MAXW, 0, 1'b1);

    // Timeout after LEN_LO, then a good frame.
    start_scenario();
    send_byte(MAGIC, 0);
    send_byte(8'h01, 0);
    idle(TMO - 1);
    check("tmo pre error", error, 1'b0);
    check("tmo pre busy", busy, 1'b1);
    idle(1);
    check("tmo error", error, 1'b1);
    check("tmo busy", busy, 1'b0);
    exp_words.delete();
    finish_check("tmo", 0, 1, 1'b0);
    start_scenario();
    make_frame(2, 16'd2);
    send_frame_all();
    finish_check("after tmo", 2, 0, 1'b1);

    // Asynchronous reset mid-frame, then a fresh frame.
    send_byte(MAGIC, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h34, 0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);
    start_scenario();
    make_frame(1, 16'd1);
    send_frame_all();
    finish_check("after reset", 1, 0, 1'b1);

    for (int unsigned i = 0; i < 40; i++) run_random($urandom_range(0, 3), i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
